// File: rtl/arb_pkg.sv
// Shared types and the reference round-robin pick for the 16-way arbiter.
// The pick function scans from ptr with wrap-around and returns a one-hot (or zero) vector.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int ARB_N_DEFAULT = 16;

  function automatic logic [ARB_N_DEFAULT-1:0] rr_pick(
    input logic [ARB_N_DEFAULT-1:0] req,
    input int unsigned              ptr
  );
    logic [ARB_N_DEFAULT-1:0] result;
    int unsigned              idx;
    result = '0;
    for (int k = 0; k < ARB_N_DEFAULT; k++) begin
      idx = (ptr + k) % ARB_N_DEFAULT;
      if (req[idx] && result == '0) result[idx] = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
// The request vector is doubled so the wrap-around becomes a plain lowest-set-bit search.
module rr_pick_onehot #(
  parameter  int N  = 16,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] iso;

  assign dbl    = {req, req};
  // Lower copy keeps only bits >= ptr; upper copy supplies the wrapped candidates.
  assign masked = dbl & ({(2*N){1'b1}} << ptr);
  assign iso    = masked & (~masked + (2*N)'(1));
  assign onehot = iso[N-1:0] | iso[2*N-1:N];

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter feeding a 16-to-4 encoder: registered one-hot grant, hold limit,
// forced-release timeout pulse and a mandatory idle bubble between consecutive grants.
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int MAX_HOLD = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         owner_done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD);

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] hold_cnt;

  logic [N-1:0]  pick;
  logic [PW-1:0] pick_idx;
  logic          owner_gone;
  logic          hold_expired;

  rr_pick_onehot #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  assign owner_gone   = !req[owner];
  assign hold_expired = (hold_cnt == CW'(MAX_HOLD - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= '0;
      owner       <= '0;
      hold_cnt    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= pick;
            grant_valid <= 1'b1;
            owner       <= pick_idx;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (owner_done || owner_gone || hold_expired) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
            ptr         <= (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
            // A voluntary release or withdrawal takes precedence over the hold limit.
            timeout     <= !owner_done && !owner_gone;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Scoreboard bench for rr_arbiter16: a cycle model queues expected outputs, a monitor
// compares them, and directed phases additionally queue the expected order of grants.
module tb_rr_arbiter16;
  import arb_pkg::*;

  localparam int N        = 16;
  localparam int MAX_HOLD = 64;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         grant_valid;
    logic         timeout;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic         owner_done = 1'b0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         timeout;

  int n_checks = 0;
  int n_errors = 0;

  exp_t         exp_q[$];
  logic [N-1:0] order_q[$];

  rr_arbiter16 #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .owner_done  (owner_done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: whole-number owner/pointer/age, outputs as seen after each edge.
  bit busy = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_age = 0;

  always @(posedge clk) begin
    exp_t e;
    logic [N-1:0] oh;
    e = '0;
    if (reset) begin
      busy = 0; m_ptr = 0; m_age = 0;
    end else if (!busy) begin
      if (req != '0) begin
        oh      = rr_pick(req, m_ptr);
        m_owner = $clog2(oh);
        busy    = 1;
        m_age   = 1;
        e       = '{grant: oh, grant_valid: 1'b1, timeout: 1'b0};
      end
    end else if (owner_done || !req[m_owner] || m_age == MAX_HOLD) begin
      e.timeout = !owner_done && req[m_owner];
      busy      = 0;
      m_ptr     = (m_owner + 1) % N;
    end else begin
      m_age++;
      e = '{grant: N'(1) << m_owner, grant_valid: 1'b1, timeout: 1'b0};
    end
    exp_q.push_back(e);
  end

  // Monitor: compares each cycle's outputs and the order of newly started grants.
  initial begin
    exp_t e;
    logic prev_gv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("grant_valid", 32'(grant_valid), 32'(e.grant_valid));
        check("timeout", 32'(timeout), 32'(e.timeout));
      end
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (grant_valid && !prev_gv && order_q.size() > 0)
        check("grant_order", 32'(grant), 32'(order_q.pop_front()));
      prev_gv = grant_valid;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    req = '0; owner_done = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_level(input logic level, input string name);
    int budget = 200;
    while (grant_valid !== level && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check({name, "_timeout"}, 32'(grant_valid), 32'(level));
  endtask

  task automatic pulse_done();
    owner_done = 1'b1;
    @(negedge clk);
    owner_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle with no requests: monitor expects all-zero outputs.
    repeat (10) @(negedge clk);

    // Single requester 0 held five cycles, then released.
    order_q.push_back(16'h0001);
    req = 16'h0001;
    wait_level(1'b1, "req0_grant");
    repeat (4) @(negedge clk);
    pulse_done();

    // All requesters: ascending order with wrap.
    apply_reset();
    for (int i = 0; i < N; i++) order_q.push_back(N'(1) << i);
    order_q.push_back(16'h0001);
    req = 16'hFFFF;
    for (int i = 0; i <= N; i++) begin
      wait_level(1'b1, "fair_grant");
      pulse_done();
    end

    // Sparse pair 4 and 10 with wrap back to 4.
    apply_reset();
    order_q.push_back(16'h0010);
    order_q.push_back(16'h0400);
    order_q.push_back(16'h0010);
    req = 16'h0410;
    for (int i = 0; i < 3; i++) begin
      wait_level(1'b1, "pair_grant");
      pulse_done();
    end

    // Requester 15 never releases: forced release after MAX_HOLD, then regrant.
    apply_reset();
    order_q.push_back(16'h8000);
    order_q.push_back(16'h8000);
    req = 16'h8000;
    wait_level(1'b1, "hold_grant");
    wait_level(1'b0, "hold_release");
    wait_level(1'b1, "hold_regrant");
    pulse_done();

    // Owner 3 withdraws while 7 waits; then reset mid-grant returns ptr to 0.
    apply_reset();
    order_q.push_back(16'h0008);
    order_q.push_back(16'h0080);
    order_q.push_back(16'h0001);
    req = 16'h0088;
    wait_level(1'b1, "withdraw_grant");
    repeat (3) @(negedge clk);
    req = 16'h0080;
    wait_level(1'b0, "withdraw_drop");
    wait_level(1'b1, "withdraw_next");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req = 16'hFFFF;
    @(negedge clk);
    reset = 1'b0;
    wait_level(1'b1, "post_reset_grant");
    pulse_done();

    // Randomized traffic, releases, withdrawals and occasional resets.
    apply_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(7) == 0)
        req = N'($urandom) & N'($urandom) & N'($urandom_range(1) ? 32'hFFFF : $urandom);
      owner_done = ($urandom_range(15) == 0);
      reset = ($urandom_range(299) == 0);
      @(negedge clk);
    end
    reset = 1'b0; owner_done = 1'b0; req = '0;
    repeat (4) @(negedge clk);

    check("order_queue_drained", 32'(order_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter for up to 16 requesters.
- Sits directly upstream of the 16-to-4 binary encoder. grant drives encoder_in and grant_valid drives enable.
- Guarantees encoder_in is zero or exactly one-hot.
- grant_valid tells consumers apart two cases that both encode to binary 0: "granted requester 0" and "no grant".

Parameters:
- N, 16, number of request lines. Must be 16 when feeding the encoder; legal range 2..16.
- MAX_HOLD, 64, maximum cycles a grant may be held before forced release. Legal range 2..256.
- CW, $clog2(MAX_HOLD), width of the hold counter. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request lines, level-sensitive; bit i = requester i.
- release  input  1  owner done. Honoured only while grant_valid=1.
- grant  output  N  registered one-hot grant; all-zero when idle.
- grant_valid  output  1  high exactly when grant is non-zero.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset (sampled at posedge clk, reset=1):
  - grant=0, grant_valid=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Reset asserted mid-grant drops the grant on the next edge; no timeout pulse is produced.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0: select the first set bit scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap-around).
  - Next edge: grant=onehot(sel), grant_valid=1, state=GRANT, counter=0.
  - Latency from req to grant is 1 cycle.
  - If req == 0: stay in IDLE, outputs 0.
- GRANT: the release condition is any one of:
  - (a) release=1;
  - (b) req[owner]=0, i.e. the owner withdrew;
  - (c) counter == MAX_HOLD-1.
- GRANT, release condition true:
  - Next edge: grant=0, grant_valid=0, state=IDLE, ptr=(owner+1) mod N.
  - timeout=1 for that one cycle only if (c) is the only cause. If release=1 or withdrawal coincides with (c), release wins and timeout=0.
- GRANT, otherwise: counter += 1; grant is held unchanged.
- Back-to-back: at least one idle cycle (grant=0) always separates two grants. Consumers may rely on this bubble.
- Changes to req bits other than the owner's during GRANT are ignored until the return to IDLE.
- release asserted in IDLE: ignored.
- Fairness: with all N requesters continuously asserted, each is granted once per N grants in ascending index order.
- grant is never multi-hot. Violating this is a design error and is covered by an assertion in the bench.

Decomposition:
- Shared package arb_pkg:
  - typedef arb_state_t {IDLE, GRANT}
  - localparam ARB_N_DEFAULT=16
  - function rr_pick(req, ptr) returning one-hot. The same function is reused by the bench model.
- One natural sub-module: rr_pick_onehot.
  - Purely combinational: double-width req masked by ptr, lowest-set-bit isolate, fold back to N bits.
  - The top level holds the FSM, ptr register, hold counter and output registers.

Test Plan:
- Reset then req=16'h0000 for 10 cycles -> grant=0, grant_valid=0, timeout=0 throughout.
- req=16'h0001, release pulse at cycle 5 -> grant=16'h0001, grant_valid=1 from cycle 1 through cycle 5; grant=0 at cycle 6; encoder output 0 with enable=1 during the grant.
- req=16'hFFFF held, release pulsed each time the grant appears -> grant sequence 0001,0002,0004,...,8000,0001 with one zero cycle between each.
- req=16'h0410, ptr=0 -> grant 0010 (encoder 4). After release: grant 0400 (encoder 10). Then 0010 again (wrap).
- req=16'h8000 held, no release, MAX_HOLD=64 -> grant held 64 cycles, then grant=0 with timeout=1 for exactly one cycle, then regrant 8000 the following cycle.
- Owner 3 drops req mid-grant while req[7]=1 -> grant clears next edge, timeout=0, next grant 0080. Separately, reset asserted during a grant -> grant=0 next edge and ptr returns to 0.
